// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIBBLE_W = 4;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_seq_cla4.sv
// Combinational 4-bit carry-lookahead slice, reused once per nibble pass.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a | b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  // p is a|b (lookahead form), so the sum bit needs the true xor
  assign s = a ^ b ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial WIDTH-bit add/sub with valid/ready handshakes.
// Define NIBBLE_ADD_SEQ_B2B_EN to accept a new operation on the result handshake edge.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t                    state;
  logic   [IW-1:0]           idx;
  logic                      carry;
  logic   [WIDTH-1:0]        opa;
  logic   [WIDTH-1:0]        opb;
  logic   [WIDTH-NIBBLE_W-1:0] res;

  logic [NIBBLE_W-1:0] s;
  logic                c3;
  logic                c4;
  logic                accept;

  cla4_slice u_slice (
    .a  (opa[NIBBLE_W-1:0]),
    .b  (opb[NIBBLE_W-1:0]),
    .cin(carry),
    .s  (s),
    .c3 (c3),
    .c4 (c4)
  );

`ifdef NIBBLE_ADD_SEQ_B2B_EN
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept = in_valid && in_ready;

  // Operands shift right each pass so the slice always sees bit 0; the low
  // result nibbles shift in from the top of res and land aligned on the last pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      carry        <= 1'b0;
      out_valid    <= 1'b0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_sum      <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          opa   <= opa >> NIBBLE_W;
          opb   <= opb >> NIBBLE_W;
          res   <= {s, res[WIDTH-NIBBLE_W-1:NIBBLE_W]};
          carry <= c4;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            out_sum      <= {s, res};
            out_cout     <= c4;
            out_overflow <= c3 ^ c4;
            out_valid    <= 1'b1;
            idx          <= '0;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        opa   <= in_a;
        opb   <= in_sub ? ~in_b : in_b;
        carry <= in_sub;
        idx   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (WIDTH=32): vector table plus multi-cycle corner sequences.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_cout    (out_cout),
    .out_overflow(out_overflow),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Present one operation, return edges from accept to out_valid (capped).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("busy_drop", busy, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int hits[3];
    int nhits;
    int period;

    vecs[0] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h4B4B4B4B, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_cout", out_cout, 1'b0);
    chk("rst_ovf", out_overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("latency_%0d", i), lat, 8);
      chk($sformatf("sum_%0d", i), out_sum, vecs[i].sum);
      chk($sformatf("cout_%0d", i), out_cout, vecs[i].cout);
      chk($sformatf("ovf_%0d", i), out_overflow, vecs[i].ovf);
      chk($sformatf("busy_done_%0d", i), busy, 1'b1);
      finish_op();
    end

    // Backpressure: hold DONE, poke in_valid, outputs must not move
    start_op(32'h0000000F, 32'h00000001, 1'b0, lat);
    chk("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_a = 32'h11111111; in_b = 32'h22222222; in_sub = 1'b1;
      in_valid = (k % 2 == 0);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, 32'h00000010);
      chk("bp_cout", out_cout, 1'b0);
      chk("bp_ovf", out_overflow, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op();

    // Reset on the third RUN edge discards the operation
    @(negedge clk);
    in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", out_sum, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    nhits = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) nhits++;
    end
    chk("midrst_no_result", nhits, 0);
    out_ready = 1'b0;

    // Continuous streaming
`ifdef NIBBLE_ADD_SEQ_B2B_EN
    period = 9;
`else
    period = 10;
`endif
    @(negedge clk);
    in_a = 32'h7FFFFFFF; in_b = 32'h00000001; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    nhits = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (out_valid && nhits < 3) begin
        hits[nhits] = k;
        chk("b2b_sum", out_sum, 32'h80000000);
        chk("b2b_ovf", out_overflow, 1'b1);
        nhits++;
      end
    end
    chk("b2b_count", nhits, 3);
    if (nhits == 3) begin
      chk("b2b_first", hits[0], 8);
      chk("b2b_period1", hits[1] - hits[0], period);
      chk("b2b_period2", hits[2] - hits[1], period);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_busy", busy, 1'b0);
    chk("drain_in_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
